mc_main_ctrl: RTL

- Main control FSM for the multi-cycle MIPS CPU.
- Sequences the shared ALU, memory, IR, PC and register file through IF/ID/EX/MEM/WB steps, one state per cycle.
- Drives the 3-bit ALUOp that the ALU control decoder consumes: 000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt, 110 xor.
- Sits in the top-level CPU beside the datapath.

---
 rtl/mc_main_ctrl_pkg.sv | 72 +++++++
 rtl/mc_main_ctrl_if.sv | 46 ++++
 rtl/mc_main_ctrl_iop_dec.sv | 27 ++
 rtl/mc_main_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mc_main_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// opcodes, ALUOp encodings, state encodings, mux select constants and
// the packed control-word struct.
package mc_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp encodings consumed by the ALU control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM states; encodings 12..15 are unused and recover to S_IF
  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_MWB = 4'd4,
    S_MW  = 4'd5,
    S_EXR = 4'd6,
    S_RWB = 4'd7,
    S_BEQ = 4'd8,
    S_JMP = 4'd9,
    S_EXI = 4'd10,
    S_IWB = 4'd11
  } state_t;

  // Moore control word held in a register alongside the state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Control bus between the main control FSM and the datapath.
// master = controller (drives controls), slave = datapath (drives op).
// With MC_MEM_WAIT_EN defined the bus also carries mem_ready from memory.
// Handshake: mem_ready is a level sampled at each rising clk edge; the
// controller advances out of IF/MR/MW only on an edge where it is 1.
interface mc_main_ctrl_if;
  logic [5:0] op;
`ifdef MC_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;

  modport master (
    input  op,
`ifdef MC_MEM_WAIT_EN
    input  mem_ready,
`endif
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp,
           PCSource, illegal_op
  );

  modport slave (
    output op,
`ifdef MC_MEM_WAIT_EN
    output mem_ready,
`endif
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp,
           PCSource, illegal_op
  );
endinterface

// File: rtl/mc_main_ctrl_iop_dec.sv
// I-type ALU instruction decoder: maps op to ALUOp and immediate
// extension mode for the EXI state, and flags whether op is one of them.
module mc_iop_dec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic       is_iop
);

  // Logical immediates zero-extend; arithmetic/compare sign-extend.
  always_comb begin
    alu_op = ALUOP_ADD;
    ext_op = 1'b1;
    is_iop = 1'b1;
    case (op)
      OP_ADDI: begin alu_op = ALUOP_ADD; ext_op = 1'b1; end
      OP_ANDI: begin alu_op = ALUOP_AND; ext_op = 1'b0; end
      OP_ORI:  begin alu_op = ALUOP_OR;  ext_op = 1'b0; end
      OP_SLTI: begin alu_op = ALUOP_SLT; ext_op = 1'b1; end
      OP_XORI: begin alu_op = ALUOP_XOR; ext_op = 1'b0; end
      default: is_iop = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU. One state per cycle,
// sequencing IF/ID/EX/MEM/WB. The control word is registered together
// with the state (computed from the next state), so outputs are a pure
// function of the current state. Write strobes and illegal_op are gated
// off while rst is high. Optional feature macro: MC_MEM_WAIT_EN adds
// mem_ready and stalls IF/MR/MW until memory is ready.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  mc_main_ctrl_if.master     bus,
  output logic [STATE_W-1:0] dbg_state
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl_q;
  logic [2:0] iop_alu;
  logic       iop_ext;
  logic       iop_legal;
  logic       mem_ok;
  logic       fetch_ok;
  logic       op_known;

  mc_iop_dec u_iop_dec (
    .op     (bus.op),
    .alu_op (iop_alu),
    .ext_op (iop_ext),
    .is_iop (iop_legal)
  );

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // Control word for a state; EXI also depends on the I-type decode,
  // which is valid when leaving ID because op is stable from then on.
  function automatic ctrl_t ctrl_of(state_t s, logic [2:0] ialu, logic iext);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.ext_op    = 1'b1;
      end
      S_MA: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = 1'b1;
      end
      S_MR: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MW: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_EXI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ialu;
        c.ext_op    = iext;
      end
      S_IWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_known = (bus.op == OP_LW) || (bus.op == OP_SW) ||
                    (bus.op == OP_RTYPE) || (bus.op == OP_BEQ) ||
                    (bus.op == OP_J) || iop_legal;

  // Next-state decode; memory states wait on mem_ok.
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = mem_ok ? S_ID : S_IF;
      S_ID: begin
        if ((bus.op == OP_LW) || (bus.op == OP_SW)) state_nxt = S_MA;
        else if (bus.op == OP_RTYPE)                 state_nxt = S_EXR;
        else if (bus.op == OP_BEQ)                   state_nxt = S_BEQ;
        else if (bus.op == OP_J)                     state_nxt = S_JMP;
        else if (iop_legal)                          state_nxt = S_EXI;
        else                                         state_nxt = S_IF;
      end
      S_MA:  state_nxt = (bus.op == OP_LW) ? S_MR : S_MW;
      S_MR:  state_nxt = mem_ok ? S_MWB : S_MR;
      S_MW:  state_nxt = mem_ok ? S_IF : S_MW;
      S_EXR: state_nxt = S_RWB;
      S_EXI: state_nxt = S_IWB;
      default: state_nxt = S_IF;
    endcase
  end

  // State register and registered control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IF;
      ctrl_q <= ctrl_of(S_IF, iop_alu, iop_ext);
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_of(state_nxt, iop_alu, iop_ext);
    end
  end

  // IR/PC update in IF only completes on the cycle memory delivers.
  assign fetch_ok = mem_ok || (state != S_IF);

  assign bus.PCWrite     = ctrl_q.pc_write & fetch_ok & ~rst;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond & ~rst;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write & ~rst;
  assign bus.IRWrite     = ctrl_q.ir_write & fetch_ok & ~rst;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.RegWrite    = ctrl_q.reg_write & ~rst;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ExtOp       = ctrl_q.ext_op;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.illegal_op  = (state == S_ID) & ~op_known & ~rst;

  assign dbg_state = STATE_W'(state);

endmodule
